systolic_mm_engine: RTL and testbench
=====================================

Name: systolic_mm_engine

Overview:
- Self-sequencing, output-stationary SIZE x SIZE systolic matrix-multiply engine.
- Accepts one k-slice per handshake: column k of A and row k of B. Skews the slice internally, runs a variable-length inner dimension, and presents the full C tile through a valid/ready output handshake.
- Generalises the bare systolic array: internal skewing, run-time K, signed/unsigned mode, accumulate-across-ops, backpressure, and overflow detection.

Parameters:
- SIZE, 4, array dimension (rows = columns), >= 2
- IN_WIDTH, 8, operand width
- OUT_WIDTH, 32, accumulator/result width, >= 2*IN_WIDTH
- MAX_K, 256, largest supported inner dimension

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- k_len  in  $clog2(MAX_K+1)  inner dimension; latched at start
- signed_mode  in  1  1 = two's-complement operands; latched at start
- accumulate  in  1  0 = clear accumulators at start, 1 = add onto retained C; latched at start
- a_vec  in  IN_WIDTH x [SIZE]  a_vec[i] = A[i][k]
- b_vec  in  IN_WIDTH x [SIZE]  b_vec[j] = B[k][j]
- in_valid  in  1  slice valid
- in_ready  out  1  engine accepts a slice
- out  out  OUT_WIDTH x [SIZE][SIZE]  C tile, out[i][j]
- out_valid  out  1  C tile complete
- out_ready  in  1  consumer takes C
- busy  out  1  state != IDLE
- ovf  out  1  sticky per-op accumulator wrap flag

Behaviour:
- Reset (async, any state): FSM -> IDLE; all accumulators, out, skew registers, and counters -> 0; in_ready = out_valid = busy = ovf = 0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start = 1 latches k_len, signed_mode, and accumulate.
  - accumulate = 0 zeroes every accumulator on that same edge and clears ovf. accumulate = 1 keeps C and ovf.
  - Goes to LOAD, or to DRAIN if k_len = 0.
- LOAD:
  - in_ready = 1 while accepted count < k_len.
  - Slice accepted on the edge where in_valid && in_ready.
  - in_valid = 0 inserts a bubble. The valid token travels with the data, so PEs do not MAC on bubbles.
  - Goes to DRAIN on the edge that accepts slice k_len-1.
- DRAIN:
  - Counter runs 2*SIZE-1 cycles, then goes to DONE.
  - PE(i,j) consumes slice k on edge t_k + 1 + i + j, where t_k is that slice's accept edge.
  - out_valid rises exactly 2*SIZE cycles after the last accept edge; for k_len = 0, it rises 2*SIZE cycles after start.
- DONE:
  - out_valid = 1; out is stable and equals the accumulators.
  - Goes to IDLE on the edge where out_ready = 1. Accumulators are retained.
  - start is ignored in every state except IDLE.
- Arithmetic:
  - Product is a 2*IN_WIDTH-bit value: signed multiply if signed_mode, otherwise unsigned.
  - Product is sign- or zero-extended to OUT_WIDTH and added modulo 2^OUT_WIDTH.
- ovf sets if any PE add overflows: signed overflow in signed_mode, carry-out in unsigned mode. It holds until the next start with accumulate = 0, or until reset.
- Operand a moves right and b moves down one PE per cycle, each with its valid bit; edge PEs discard outgoing data.
- in_ready = 0 in IDLE, DRAIN, and DONE.

Decomposition:
- Shared package systolic_pkg holds:
  - the state enum (IDLE, LOAD, DRAIN, DONE)
  - function drain_cycles(SIZE) = 2*SIZE-1
  - operand/accumulator typedef helpers parametrised via localparams
- One sub-module, systolic_pe:
  - registered a/b/valid pass-through plus MAC
  - inputs: clear, signed_mode
  - outputs: acc, ovf
- Top-level contents:
  - input skew delay lines (row i delayed i cycles, column j delayed j cycles)
  - PE grid via generate
  - FSM and counters
  - ovf OR-reduction

Test Plan:
- SIZE = 2, unsigned, accumulate = 0, k_len = 2; slices a = {1,3}, b = {5,6}, then a = {2,4}, b = {7,8} -> out = [[19,22],[43,50]]; out_valid exactly 4 cycles after the 2nd accept; ovf = 0.
- Repeat the same op with accumulate = 1 -> out = [[38,44],[86,100]]. Then accumulate = 0 with k_len = 1, a = {1,1}, b = {1,1} -> [[1,1],[1,1]].
- signed_mode = 1, k_len = 2; a = {-1,0}, b = {-1,0}, then a = {0,-1}, b = {0,-1} -> out = [[1,0],[0,1]]. The same bits with signed_mode = 0 -> [[65025,0],[0,65025]].
- Bubble and backpressure:
  - in_valid low for 2 cycles between slices of the first scenario -> same result, out_valid 2 cycles later.
  - Hold out_ready low for 5 cycles -> out stable, in_ready = 0, a start pulse is ignored, busy = 1.
- OUT_WIDTH = 16, unsigned, k_len = 2, all operands 255 -> every out = 64514 and ovf = 1. A following accumulate = 0 op clears ovf.
- Assert reset for 1 cycle mid-LOAD after 1 accepted slice -> everything is 0 immediately (async). A subsequent full op from the first scenario gives the correct result with no residue.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared definitions for the systolic matrix-multiply engine:
//                FSM state encoding, drain-length helper and default-width
//                operand/accumulator typedefs.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int c_default_in_width  = 8;
    localparam int c_default_out_width = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [c_default_in_width-1:0]    operand_t;
    typedef logic [2*c_default_in_width-1:0]  product_t;
    typedef logic [c_default_out_width-1:0]   acc_t;

    // Cycles after the last accept until the far-corner PE has consumed it.
    function automatic int drain_cycles(input int size);
        return 2 * size - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pe
//  Description : Output-stationary processing element. Registers a (moving
//                right) and b (moving down) with their valid bits, and
//                multiply-accumulates when both incoming operands are valid.
//  Ports       : clk, reset            clock / async active-high reset
//                clear                 zero acc and ovf on this edge
//                signed_mode           1 = two's-complement operands
//                a_in/a_valid_in       operand from the left neighbour
//                b_in/b_valid_in       operand from the upper neighbour
//                a_out/a_valid_out     registered a to the right neighbour
//                b_out/b_valid_out     registered b to the lower neighbour
//                acc                   accumulator
//                ovf                   sticky accumulator wrap flag
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_pe #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 signed_mode,
    input  logic [IN_WIDTH-1:0]  a_in,
    input  logic                 a_valid_in,
    input  logic [IN_WIDTH-1:0]  b_in,
    input  logic                 b_valid_in,
    output logic [IN_WIDTH-1:0]  a_out,
    output logic                 a_valid_out,
    output logic [IN_WIDTH-1:0]  b_out,
    output logic                 b_valid_out,
    output logic [OUT_WIDTH-1:0] acc,
    output logic                 ovf
);

    localparam int c_pw = 2 * IN_WIDTH;

    logic [IN_WIDTH-1:0]  r_a;
    logic [IN_WIDTH-1:0]  r_b;
    logic                 r_av;
    logic                 r_bv;
    logic [OUT_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    logic [c_pw-1:0]      w_prod_s;
    logic [c_pw-1:0]      w_prod_u;
    logic [OUT_WIDTH-1:0] w_ext;
    logic [OUT_WIDTH:0]   w_sum;
    logic                 w_add_ovf;
    logic                 w_mac;

    // The low 2N bits of a product of sign-extended operands equal the
    // signed product, so both flavours use a plain unsigned multiplier.
    assign w_prod_s = {{IN_WIDTH{a_in[IN_WIDTH-1]}}, a_in} * {{IN_WIDTH{b_in[IN_WIDTH-1]}}, b_in};
    assign w_prod_u = {{IN_WIDTH{1'b0}}, a_in} * {{IN_WIDTH{1'b0}}, b_in};

    if (OUT_WIDTH > c_pw) begin : g_ext
        assign w_ext = signed_mode ? {{(OUT_WIDTH-c_pw){w_prod_s[c_pw-1]}}, w_prod_s}
                                   : {{(OUT_WIDTH-c_pw){1'b0}}, w_prod_u};
    end else begin : g_no_ext
        assign w_ext = signed_mode ? w_prod_s : w_prod_u;
    end

    assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};

    // Signed: operands agree in sign but the result does not. Unsigned: carry.
    assign w_add_ovf = signed_mode
                     ? ((r_acc[OUT_WIDTH-1] == w_ext[OUT_WIDTH-1]) &&
                        (w_sum[OUT_WIDTH-1] != r_acc[OUT_WIDTH-1]))
                     : w_sum[OUT_WIDTH];

    assign w_mac = a_valid_in && b_valid_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_av  <= 1'b0;
            r_bv  <= 1'b0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_a  <= a_in;
            r_b  <= b_in;
            r_av <= a_valid_in;
            r_bv <= b_valid_in;
            if (clear) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_mac) begin
                r_acc <= w_sum[OUT_WIDTH-1:0];
                r_ovf <= r_ovf | w_add_ovf;
            end
        end
    end

    assign a_out       = r_a;
    assign a_valid_out = r_av;
    assign b_out       = r_b;
    assign b_valid_out = r_bv;
    assign acc         = r_acc;
    assign ovf         = r_ovf;

endmodule
`default_nettype wire

// File: rtl/systolic_mm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_mm_engine
//  Description : Self-sequencing output-stationary SIZE x SIZE systolic
//                matrix multiplier. Takes one k-slice (column k of A, row k
//                of B) per handshake, skews it internally, and presents the
//                C tile through a valid/ready handshake.
//  Ports       : clk, reset            clock / async active-high reset
//                start                 begin operation (IDLE only)
//                k_len                 inner dimension, latched at start
//                signed_mode           operand signedness, latched at start
//                accumulate            0 = clear C at start, 1 = add onto C
//                a_vec / b_vec         slice inputs, a_vec[i]=A[i][k], b_vec[j]=B[k][j]
//                in_valid / in_ready   slice handshake
//                out                   C tile, out[i][j]
//                out_valid / out_ready result handshake
//                busy                  engine not idle
//                ovf                   sticky accumulator wrap flag
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32,
    parameter int MAX_K     = 256
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [$clog2(MAX_K+1)-1:0]                 k_len,
    input  logic                                       signed_mode,
    input  logic                                       accumulate,
    input  logic [SIZE-1:0][IN_WIDTH-1:0]              a_vec,
    input  logic [SIZE-1:0][IN_WIDTH-1:0]              b_vec,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic [SIZE-1:0][SIZE-1:0][OUT_WIDTH-1:0]   out,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       busy,
    output logic                                       ovf
);

    localparam int c_kw           = $clog2(MAX_K + 1);
    localparam int c_drain_cycles = drain_cycles(SIZE);
    localparam int c_dw           = $clog2(c_drain_cycles + 1);

    state_e           r_state;
    logic [c_kw-1:0]  r_k_len;
    logic [c_kw-1:0]  r_acc_cnt;
    logic [c_dw-1:0]  r_drain_cnt;
    logic             r_signed;

    logic             w_accept;
    logic             w_clear;

    logic [IN_WIDTH-1:0] w_a_h  [SIZE][SIZE+1];
    logic                w_av_h [SIZE][SIZE+1];
    logic [IN_WIDTH-1:0] w_b_v  [SIZE+1][SIZE];
    logic                w_bv_v [SIZE+1][SIZE];
    logic [SIZE*SIZE-1:0] w_pe_ovf;

    assign in_ready  = (r_state == LOAD) && (r_acc_cnt < r_k_len);
    assign w_accept  = in_valid && in_ready;
    assign w_clear   = (r_state == IDLE) && start && !accumulate;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign ovf       = |w_pe_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_k_len     <= '0;
            r_acc_cnt   <= '0;
            r_drain_cnt <= '0;
            r_signed    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k_len     <= k_len;
                        r_signed    <= signed_mode;
                        r_acc_cnt   <= '0;
                        r_drain_cnt <= '0;
                        r_state     <= (k_len == '0) ? DRAIN : LOAD;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + c_kw'(1);
                        if (r_acc_cnt + c_kw'(1) == r_k_len) begin
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Lands in DONE 2*SIZE edges after the last accept.
                    if (r_drain_cnt == c_dw'(c_drain_cycles)) begin
                        r_state <= DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + c_dw'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Row i of A is delayed 1+i edges and column j of B 1+j edges, so the
    // operands of slice k meet at PE(i,j) on edge t_k + 1 + i + j.
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_a_skew
        logic [IN_WIDTH-1:0] r_d [gi+1];
        logic                r_v [gi+1];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s <= gi; s++) begin
                    r_d[s] <= '0;
                    r_v[s] <= 1'b0;
                end
            end else begin
                r_d[0] <= a_vec[gi];
                r_v[0] <= w_accept;
                for (int s = 1; s <= gi; s++) begin
                    r_d[s] <= r_d[s-1];
                    r_v[s] <= r_v[s-1];
                end
            end
        end
        assign w_a_h[gi][0]  = r_d[gi];
        assign w_av_h[gi][0] = r_v[gi];
    end

    for (genvar gj = 0; gj < SIZE; gj++) begin : g_b_skew
        logic [IN_WIDTH-1:0] r_d [gj+1];
        logic                r_v [gj+1];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s <= gj; s++) begin
                    r_d[s] <= '0;
                    r_v[s] <= 1'b0;
                end
            end else begin
                r_d[0] <= b_vec[gj];
                r_v[0] <= w_accept;
                for (int s = 1; s <= gj; s++) begin
                    r_d[s] <= r_d[s-1];
                    r_v[s] <= r_v[s-1];
                end
            end
        end
        assign w_b_v[0][gj]  = r_d[gj];
        assign w_bv_v[0][gj] = r_v[gj];
    end

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
            systolic_pe #(
                .IN_WIDTH  (IN_WIDTH),
                .OUT_WIDTH (OUT_WIDTH)
            ) u_pe (
                .clk         (clk),
                .reset       (reset),
                .clear       (w_clear),
                .signed_mode (r_signed),
                .a_in        (w_a_h[gi][gj]),
                .a_valid_in  (w_av_h[gi][gj]),
                .b_in        (w_b_v[gi][gj]),
                .b_valid_in  (w_bv_v[gi][gj]),
                .a_out       (w_a_h[gi][gj+1]),
                .a_valid_out (w_av_h[gi][gj+1]),
                .b_out       (w_b_v[gi+1][gj]),
                .b_valid_out (w_bv_v[gi+1][gj]),
                .acc         (out[gi][gj]),
                .ovf         (w_pe_ovf[gi*SIZE+gj])
            );
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_mm_engine
//  Description : Scoreboard bench for systolic_mm_engine. A matrix-level
//                reference model produces the expected C tile, ovf flag and
//                out_valid arrival cycle for each operation; a monitor pops
//                and compares whenever out_valid rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_mm_engine;

    localparam int SIZE = 3;
    localparam int IW   = 8;
    localparam int OW   = 16;
    localparam int MAXK = 16;
    localparam int KW   = $clog2(MAXK + 1);

    logic                                clk = 1'b0;
    logic                                reset;
    logic                                start;
    logic [KW-1:0]                       k_len;
    logic                                signed_mode;
    logic                                accumulate;
    logic [SIZE-1:0][IW-1:0]             a_vec;
    logic [SIZE-1:0][IW-1:0]             b_vec;
    logic                                in_valid;
    logic                                in_ready;
    logic [SIZE-1:0][SIZE-1:0][OW-1:0]   out;
    logic                                out_valid;
    logic                                out_ready;
    logic                                busy;
    logic                                ovf;

    systolic_mm_engine #(
        .SIZE(SIZE), .IN_WIDTH(IW), .OUT_WIDTH(OW), .MAX_K(MAXK)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .signed_mode(signed_mode), .accumulate(accumulate),
        .a_vec(a_vec), .b_vec(b_vec), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [SIZE*SIZE-1:0][OW-1:0] c;
        logic                         ovf;
        int                           rise;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_err    = 0;

    longint ref_c [SIZE][SIZE];
    bit     ref_ovf;
    int     op_a [MAXK][SIZE];
    int     op_b [MAXK][SIZE];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input int v);
        return (v >= (1 << (IW - 1))) ? longint'(v - (1 << IW)) : longint'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                ref_c[i][j] = 0;
        ref_ovf = 1'b0;
    endtask

    // C += A*B over k slices with the arithmetic rules of the engine.
    task automatic model_op(input int k, input bit sgn, input bit acc);
        longint modv;
        longint half;
        longint p;
        longint cs;
        longint tsum;
        modv = longint'(1) << OW;
        half = modv / 2;
        if (!acc) model_reset();
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    if (sgn) begin
                        p    = sx(op_a[kk][i]) * sx(op_b[kk][j]);
                        cs   = (ref_c[i][j] >= half) ? ref_c[i][j] - modv : ref_c[i][j];
                        tsum = cs + p;
                        if (tsum >= half || tsum < -half) ref_ovf = 1'b1;
                    end else begin
                        p    = longint'(op_a[kk][i]) * longint'(op_b[kk][j]);
                        tsum = ref_c[i][j] + p;
                        if (tsum >= modv) ref_ovf = 1'b1;
                    end
                    ref_c[i][j] = (((ref_c[i][j] + p) % modv) + modv) % modv;
                end
            end
        end
    endtask

    task automatic set_slice(input int kk, input int a0, input int a1, input int a2,
                             input int b0, input int b1, input int b2);
        op_a[kk][0] = a0; op_a[kk][1] = a1; op_a[kk][2] = a2;
        op_b[kk][0] = b0; op_b[kk][1] = b1; op_b[kk][2] = b2;
    endtask

    task automatic scenario1();
        set_slice(0, 1, 3, 0, 5, 6, 0);
        set_slice(1, 2, 4, 0, 7, 8, 0);
    endtask

    // Issue one operation, push its expectation, then take the result.
    task automatic run_op(input int k, input bit sgn, input bit acc,
                          input int gap, input int bub_pct, input int hold);
        int   sent;
        int   guard;
        int   last_ev;
        int   w;
        exp_t e;
        logic [SIZE-1:0][SIZE-1:0][OW-1:0] snap;

        @(negedge clk);
        start = 1'b1; k_len = KW'(k); signed_mode = sgn; accumulate = acc; in_valid = 1'b0;
        model_op(k, sgn, acc);
        last_ev = cyc;
        @(negedge clk);
        start = 1'b0;
        signed_mode = ~sgn;   // latched copy must be used from here on
        accumulate  = ~acc;
        sent = 0; guard = 0;
        while (sent < k && guard < 500) begin
            if (in_ready && ($urandom_range(99) >= bub_pct)) begin
                in_valid = 1'b1;
                for (int i = 0; i < SIZE; i++) begin
                    a_vec[i] = IW'(op_a[sent][i]);
                    b_vec[i] = IW'(op_b[sent][i]);
                end
                last_ev = cyc;
                sent++;
                @(negedge clk);
                for (int g = 0; g < gap && sent < k; g++) begin
                    in_valid = 1'b0; a_vec = $urandom; b_vec = $urandom;
                    @(negedge clk);
                end
            end else begin
                in_valid = 1'b0; a_vec = $urandom; b_vec = $urandom;
                @(negedge clk);
            end
            guard++;
        end
        in_valid = 1'b0;
        chk("slices_accepted", sent, k);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                e.c[i*SIZE+j] = OW'(ref_c[i][j]);
        e.ovf  = ref_ovf;
        e.rise = last_ev + 1 + 2 * SIZE;
        sb_q.push_back(e);

        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("out_valid_timeout", longint'(out_valid), 1);
        snap = out;
        for (int h = 0; h < hold; h++) begin
            chk("hold_out_stable", longint'(out == snap), 1);
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_busy", longint'(busy), 1);
            chk("hold_out_valid", longint'(out_valid), 1);
            if (h == 1) begin
                start = 1'b1; accumulate = 1'b0; k_len = KW'(1);
            end
            @(negedge clk);
            start = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_take", longint'(busy), 0);
        chk("acc_retained", longint'(out == snap), 1);
    endtask

    // Monitor: compare on each rising out_valid.
    bit   prev_ov = 1'b0;
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (out_valid && !prev_ov) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                for (int i = 0; i < SIZE; i++)
                    for (int j = 0; j < SIZE; j++)
                        chk($sformatf("out[%0d][%0d]", i, j), longint'(out[i][j]),
                            longint'(mon_e.c[i*SIZE+j]));
                chk("ovf", longint'(ovf), longint'(mon_e.ovf));
                chk("out_valid_cycle", cyc, mon_e.rise);
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; accumulate = 1'b0;
        a_vec = '0; b_vec = '0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out", longint'(out == '0), 1);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ovf", longint'(ovf), 0);
        reset = 1'b0;

        scenario1();
        run_op(2, 0, 0, 0, 0, 0);
        chk("s1_c00", longint'(out[0][0]), 19);
        chk("s1_c01", longint'(out[0][1]), 22);
        chk("s1_c10", longint'(out[1][0]), 43);
        chk("s1_c11", longint'(out[1][1]), 50);
        run_op(2, 0, 1, 0, 0, 0);
        chk("acc_c00", longint'(out[0][0]), 38);
        chk("acc_c11", longint'(out[1][1]), 100);
        set_slice(0, 1, 1, 0, 1, 1, 0);
        run_op(1, 0, 0, 0, 0, 0);
        chk("k1_c01", longint'(out[0][1]), 1);

        set_slice(0, 255, 0, 0, 255, 0, 0);
        set_slice(1, 0, 255, 0, 0, 255, 0);
        run_op(2, 1, 0, 0, 0, 0);
        chk("sgn_c00", longint'(out[0][0]), 1);
        chk("sgn_c01", longint'(out[0][1]), 0);
        chk("sgn_c11", longint'(out[1][1]), 1);
        run_op(2, 0, 0, 0, 0, 0);
        chk("uns_c00", longint'(out[0][0]), 65025);

        scenario1();
        run_op(2, 0, 0, 2, 0, 0);   // two bubbles between slices
        run_op(2, 0, 0, 0, 0, 5);   // consumer holds off five cycles

        set_slice(0, 255, 255, 255, 255, 255, 255);
        set_slice(1, 255, 255, 255, 255, 255, 255);
        run_op(2, 0, 0, 0, 0, 0);
        chk("wrap_c22", longint'(out[2][2]), 64514);
        chk("wrap_ovf", longint'(ovf), 1);
        scenario1();
        run_op(2, 0, 0, 0, 0, 0);
        chk("ovf_cleared", longint'(ovf), 0);
        set_slice(0, 255, 255, 255, 255, 255, 255);
        set_slice(1, 255, 255, 255, 255, 255, 255);
        run_op(2, 0, 0, 0, 0, 0);

        // Reset mid-LOAD after one accepted slice, accumulating onto the
        // wrapped tile so a missed clear is visible.
        @(negedge clk);
        start = 1'b1; k_len = KW'(3); signed_mode = 1'b0; accumulate = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a_vec = '1; b_vec = '1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out", longint'(out == '0), 1);
        chk("async_rst_in_ready", longint'(in_ready), 0);
        chk("async_rst_busy", longint'(busy), 0);
        chk("async_rst_ovf", longint'(ovf), 0);
        chk("async_rst_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        scenario1();
        run_op(2, 0, 1, 0, 0, 0);
        chk("post_rst_c00", longint'(out[0][0]), 19);
        chk("post_rst_c10", longint'(out[1][0]), 43);
        run_op(0, 0, 1, 0, 0, 0);   // k_len = 0 leaves C untouched

        for (int kk = 0; kk < MAXK; kk++)
            for (int i = 0; i < SIZE; i++) begin
                op_a[kk][i] = $urandom_range(255);
                op_b[kk][i] = $urandom_range(255);
            end
        run_op(MAXK, 1, 0, 0, 20, 0);

        for (int n = 0; n < 25; n++) begin
            int k;
            k = $urandom_range(8);
            for (int kk = 0; kk < k; kk++)
                for (int i = 0; i < SIZE; i++) begin
                    op_a[kk][i] = $urandom_range(255);
                    op_b[kk][i] = $urandom_range(255);
                end
            run_op(k, 1'($urandom_range(1)), 1'($urandom_range(1)),
                   $urandom_range(1), $urandom_range(40), $urandom_range(3));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
